// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32 x 64-bit write-back register file.
package regfile_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] regidx_t;
endpackage

// File: rtl/regfile_wb_32x64_decoder.sv
// 5:32 one-hot write-enable decoder: a 3:8 group stage feeding eight 2:4 stages.
module write_decoder_32
  import regfile_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   sel,
  output logic [NUM_REGS-1:0] out
);

  localparam logic [NUM_REGS-1:0] ZERO_MASK = ~(NUM_REGS'(1) << ZERO_REG);

  logic [7:0]          group_en;
  logic [NUM_REGS-1:0] raw_en;

  always_comb begin
    group_en = '0;
    if (en) begin
      group_en[sel[4:2]] = 1'b1;
    end
  end

  // The index bits are only looked at inside an enabled group, so an
  // undriven index while en=0 cannot produce a stray enable.
  for (genvar gi = 0; gi < 8; gi++) begin : g_sub
    assign raw_en[gi*4 +: 4] = group_en[gi] ? (4'b0001 << sel[1:0]) : 4'b0000;
  end

  assign out = raw_en & ZERO_MASK;

endmodule

// File: rtl/regfile_wb_32x64.sv
// 32 x 64-bit register file: one write-back port, two combinational read
// ports with WB->ID write-through bypass, XZR at index 31.
module regfile_wb_32x64
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  logic [NUM_REGS-1:0] write_en;
  word_t               regs_reg [NUM_REGS];
  regidx_t             read_idx [2];
  word_t               read_data [2];

  write_decoder_32 u_decoder (
    .en  (RegWrite),
    .sel (WriteReg),
    .out (write_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (write_en[i]) begin
          regs_reg[i] <= WriteData;
        end
      end
    end
  end

  assign read_idx[0] = ReadReg1;
  assign read_idx[1] = ReadReg2;

  // The decoded enable already excludes XZR, so it doubles as the bypass hit.
  for (genvar gi = 0; gi < 2; gi++) begin : g_read
    word_t stored;
    logic  bypass;

    assign stored = (read_idx[gi] == regidx_t'(ZERO_REG)) ? '0 : regs_reg[read_idx[gi]];
    assign bypass = write_en[read_idx[gi]] & ~reset;
    assign read_data[gi] = bypass ? WriteData : stored;
  end

  assign ReadData1 = read_data[0];
  assign ReadData2 = read_data[1];

endmodule
